// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its neighbours: program counter,
// instruction memory, decode and the execute-stage redirect.
interface fetch_sequencer_if;
  logic        fetch_en;
  logic [31:0] pc_addr;
  logic        pc_update;
  logic        write;
  logic [31:0] new_count;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fault;

  modport master (
    input  fetch_en, pc_addr, pc_update, imem_ack, imem_rdata,
           instr_ready, redirect, redirect_target,
    output write, new_count, imem_req, imem_addr, instr, instr_pc,
           instr_valid, fault
  );

  modport slave (
    output fetch_en, pc_addr, pc_update, imem_ack, imem_rdata,
           instr_ready, redirect, redirect_target,
    input  write, new_count, imem_req, imem_addr, instr, instr_pc,
           instr_valid, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: reads one word per instruction, hands it to decode, then
// loads the next PC (sequential or redirected) into the program counter.
//
// state  | meaning
// IDLE   | waiting for fetch_en
// ISSUE  | imem_req high, waiting for ack (timeout counted)
// HOLD   | instr_valid high, waiting for instr_ready
// UPDATE | write high, new_count presented to the PC
// SYNC   | waiting for pc_update from the PC
// FAULT  | sticky error, only rst leaves
module fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int PC_STEP        = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, UPDATE, SYNC, FAULT} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] new_count_q, new_count_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic        discard_q, discard_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      new_count_q   <= 32'h0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= 32'h0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      discard_q     <= 1'b0;
      redir_tgt_q   <= 32'h0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      new_count_q   <= new_count_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      discard_q     <= discard_d;
      redir_tgt_q   <= redir_tgt_d;
      tmo_q         <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    write_d       = 1'b0;
    new_count_d   = new_count_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    discard_d     = discard_q;
    redir_tgt_d   = redir_tgt_q;
    tmo_d         = tmo_q;

    case (state_q)
      IDLE, SYNC: begin
        if (bus.redirect) begin
          new_count_d = bus.redirect_target;
          write_d     = 1'b1;
          state_d     = UPDATE;
        end else if ((state_q == IDLE || bus.pc_update) && bus.fetch_en) begin
          imem_addr_d = bus.pc_addr;
          if (bus.pc_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            imem_req_d = 1'b1;
            tmo_d      = '0;
            state_d    = ISSUE;
          end
        end else if (state_q == SYNC && bus.pc_update) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (bus.imem_ack) begin
          imem_req_d = 1'b0;
          tmo_d      = '0;
          discard_d  = 1'b0;
          if (discard_q || bus.redirect) begin
            new_count_d = bus.redirect ? bus.redirect_target : redir_tgt_q;
            write_d     = 1'b1;
            state_d     = UPDATE;
          end else begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = imem_addr_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          imem_req_d = 1'b0;
          discard_d  = 1'b0;
          fault_d    = 1'b1;
          state_d    = FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
          // the request stays outstanding; remember where to go once it completes
          if (bus.redirect) begin
            discard_d   = 1'b1;
            redir_tgt_d = bus.redirect_target;
          end
        end
      end
      HOLD: begin
        if (bus.redirect || bus.instr_ready) begin
          instr_valid_d = 1'b0;
          new_count_d   = bus.redirect ? bus.redirect_target : instr_pc_q + 32'(PC_STEP);
          write_d       = 1'b1;
          state_d       = UPDATE;
        end
      end
      UPDATE: begin
        if (bus.redirect) begin
          new_count_d = bus.redirect_target;
          write_d     = 1'b1;
        end else begin
          state_d = SYNC;
        end
      end
      FAULT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        fault_d       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.write       = write_q;
  assign bus.new_count   = new_count_q;
  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: handshakes, stalls, redirects, faults, wrap.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.TIMEOUT_CYCLES(16), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.fetch_en = 0; bus.pc_addr = 0; bus.pc_update = 0; bus.imem_ack = 0;
    bus.imem_rdata = 0; bus.instr_ready = 0; bus.redirect = 0; bus.redirect_target = 0;
    #12;
    chk("rst_write", bus.write, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_new_count", bus.new_count, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    tick(); rst = 0;

    // basic fetch at 0
    bus.fetch_en = 1; bus.pc_addr = 32'h0;
    tick();
    chk("t1_req", bus.imem_req, 1);
    chk("t1_addr", bus.imem_addr, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0013;
    tick();
    chk("t1_instr", bus.instr, 32'h13);
    chk("t1_instr_pc", bus.instr_pc, 0);
    chk("t1_valid", bus.instr_valid, 1);
    chk("t1_req_drop", bus.imem_req, 0);
    bus.imem_ack = 0; bus.instr_ready = 1;
    tick();
    chk("t1_write", bus.write, 1);
    chk("t1_new_count", bus.new_count, 32'h4);
    chk("t1_valid_drop", bus.instr_valid, 0);
    bus.instr_ready = 0;
    tick();
    chk("t1_write_single", bus.write, 0);
    bus.pc_update = 1; bus.pc_addr = 32'h4;
    tick();
    chk("t1_next_req", bus.imem_req, 1);
    chk("t1_next_addr", bus.imem_addr, 32'h4);
    bus.pc_update = 0;

    // decode stall
    bus.imem_ack = 1; bus.imem_rdata = 32'h0040_0093;
    tick();
    bus.imem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_hold", bus.instr_valid, 1);
      chk("t2_instr_hold", bus.instr, 32'h0040_0093);
      chk("t2_no_write", bus.write, 0);
      tick();
    end
    bus.instr_ready = 1;
    tick();
    chk("t2_write", bus.write, 1);
    chk("t2_new_count", bus.new_count, 32'h8);
    bus.instr_ready = 0;
    tick();
    chk("t2_write_single", bus.write, 0);
    bus.pc_update = 1; bus.pc_addr = 32'h8;
    tick();
    chk("t3_req", bus.imem_req, 1);
    bus.pc_update = 0;

    // redirect while a request is outstanding
    bus.redirect = 1; bus.redirect_target = 32'h100;
    tick();
    bus.redirect = 0; bus.redirect_target = 0;
    chk("t3_req_kept", bus.imem_req, 1);
    tick();
    chk("t3_req_kept2", bus.imem_req, 1);
    chk("t3_addr_stable", bus.imem_addr, 32'h8);
    chk("t3_no_valid", bus.instr_valid, 0);
    tick();
    chk("t3_req_kept3", bus.imem_req, 1);
    bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 0;
    chk("t3_write", bus.write, 1);
    chk("t3_new_count", bus.new_count, 32'h100);
    chk("t3_no_valid2", bus.instr_valid, 0);
    chk("t3_req_drop", bus.imem_req, 0);
    tick();
    chk("t3_write_single", bus.write, 0);
    chk("t3_no_valid3", bus.instr_valid, 0);
    bus.fetch_en = 0; bus.pc_update = 1; bus.pc_addr = 32'h100;
    tick();
    bus.pc_update = 0;
    chk("t3_idle_no_req", bus.imem_req, 0);

    // misaligned entry
    bus.fetch_en = 1; bus.pc_addr = 32'h6;
    tick();
    chk("t4_fault", bus.fault, 1);
    chk("t4_no_req", bus.imem_req, 0);
    bus.redirect = 1; bus.redirect_target = 32'h40; bus.pc_update = 1; bus.pc_addr = 32'h0;
    tick(); tick();
    bus.redirect = 0; bus.pc_update = 0;
    chk("t4_fault_sticky", bus.fault, 1);
    chk("t4_no_write", bus.write, 0);
    chk("t4_no_req2", bus.imem_req, 0);
    bus.fetch_en = 0;
    rst = 1; #1;
    chk("t4_rst_fault", bus.fault, 0);
    chk("t4_rst_addr", bus.imem_addr, 0);
    chk("t4_rst_new_count", bus.new_count, 0);
    tick(); rst = 0;

    // timeout
    bus.fetch_en = 1; bus.pc_addr = 32'h20;
    tick();
    chk("t5_req", bus.imem_req, 1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t5_req_held", bus.imem_req, 1);
      chk("t5_no_fault", bus.fault, 0);
    end
    tick();
    chk("t5_timeout_fault", bus.fault, 1);
    chk("t5_timeout_req", bus.imem_req, 0);
    rst = 1; tick(); rst = 0;
    bus.pc_addr = 32'h40;
    tick();
    chk("t5_req2", bus.imem_req, 1);
    rst = 1; #1;
    chk("t5_rst_req", bus.imem_req, 0);
    tick(); rst = 0;

    // wrap at top of memory, then redirect racing with ready
    bus.pc_addr = 32'hFFFF_FFFC;
    tick();
    bus.imem_ack = 1; bus.imem_rdata = 32'h13;
    tick();
    bus.imem_ack = 0;
    chk("t6_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    bus.instr_ready = 1;
    tick();
    bus.instr_ready = 0;
    chk("t6_wrap", bus.new_count, 32'h0);
    chk("t6_wrap_write", bus.write, 1);
    chk("t6_no_fault", bus.fault, 0);
    tick();
    bus.pc_update = 1; bus.pc_addr = 32'h10;
    tick();
    bus.pc_update = 0;
    chk("t6_addr", bus.imem_addr, 32'h10);
    bus.imem_ack = 1; bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_ack = 0;
    bus.instr_ready = 1; bus.redirect = 1; bus.redirect_target = 32'h200;
    tick();
    bus.instr_ready = 0;
    chk("t6_redir_count", bus.new_count, 32'h200);
    chk("t6_redir_write", bus.write, 1);
    chk("t6_redir_valid", bus.instr_valid, 0);
    bus.redirect_target = 32'h300;
    tick();
    bus.redirect = 0;
    chk("t6_upd_redir_count", bus.new_count, 32'h300);
    chk("t6_upd_redir_write", bus.write, 1);
    tick();
    chk("t6_write_end", bus.write, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
